// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, types and state encoding for the SHA-256 message schedule
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int N_ROUNDS    = 64;
  localparam int N_MSG_WORDS = 16;

  // sigma0: rotr 7, rotr 18, shr 3
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR_C = 3;

  // sigma1: rotr 17, rotr 19, shr 10
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR_C = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } state_t;

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - message-word input and schedule-word output streams
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic       in_valid;
  logic       in_ready;
  word_t      in_word;
  logic       out_valid;
  logic       out_ready;
  word_t      out_word;
  logic [5:0] out_idx;
  logic       out_last;
  logic       busy;

  // Producer/consumer side: feeds message words, takes schedule words
  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_idx, out_last, busy
  );

  // Schedule block side
  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_idx, out_last, busy
  );

endinterface

// File: rtl/sched_sigma.sv
// rtl/sched_sigma.sv - SHA-256 small-sigma: rotr A ^ rotr B ^ shr C
module sched_sigma
  import sha256_pkg::*;
#(
  parameter int ROT_A = 7,
  parameter int ROT_B = 18,
  parameter int SHR_C = 3
) (
  input  word_t x,
  output word_t y
);

  word_t rot_a;
  word_t rot_b;
  word_t shr_c;

  assign rot_a = (x >> ROT_A) | (x << (WORD_W - ROT_A));
  assign rot_b = (x >> ROT_B) | (x << (WORD_W - ROT_B));
  assign shr_c = x >> SHR_C;

  assign y = rot_a ^ rot_b ^ shr_c;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - loads 16 message words and expands them into W[0..63]
module sha256_msg_schedule #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input logic                  clk,
  input logic                  rst,
  sha256_msg_schedule_if.slave bus
);
  import sha256_pkg::*;

  localparam logic [5:0] LOAD_LAST = 6'(N_MSG_WORDS - 1);
  localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);

  state_t state;
  state_t state_next;

  // One index serves as cnt (0..15) in LOAD and t (16..63) in EXPAND;
  // it wraps to 0 naturally after 63.
  logic [5:0] t;

  logic [WORD_W-1:0] win [16];

  word_t      out_word;
  logic [5:0] out_idx;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  logic  adv;
  logic  in_ready;
  logic  load_en;
  word_t load_word;
  word_t sig0;
  word_t sig1;
  word_t expand_word;

  sched_sigma #(
    .ROT_A(S0_ROT_A),
    .ROT_B(S0_ROT_B),
    .SHR_C(S0_SHR_C)
  ) u_sigma0 (
    .x(win[1]),
    .y(sig0)
  );

  sched_sigma #(
    .ROT_A(S1_ROT_A),
    .ROT_B(S1_ROT_B),
    .SHR_C(S1_SHR_C)
  ) u_sigma1 (
    .x(win[14]),
    .y(sig1)
  );

  assign expand_word = sig1 + win[9] + sig0 + win[0];
  assign adv         = !out_valid || bus.out_ready;

  // Next state, input acceptance and output-register load decision
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load_en    = 1'b0;
    load_word  = expand_word;
    case (state)
      LOAD: begin
        in_ready = adv;
        if (bus.in_valid && adv) begin
          load_en   = 1'b1;
          load_word = bus.in_word;
          if (t == LOAD_LAST) begin
            state_next = EXPAND;
          end
        end
      end
      EXPAND: begin
        if (adv) begin
          load_en = 1'b1;
          if (t == LAST_IDX) begin
            state_next = LOAD;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Window shift, index counter, output register and busy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      t         <= '0;
      out_word  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else begin
      if (load_en) begin
        for (int i = 0; i < 15; i++) begin
          win[i] <= win[i+1];
        end
        win[15]   <= load_word;
        out_word  <= load_word;
        out_idx   <= t;
        out_last  <= (t == LAST_IDX);
        out_valid <= 1'b1;
        t         <= t + 6'd1;
      end else if (adv) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      // A new block's first word can be accepted in the same cycle W63 is taken.
      if (load_en && state == LOAD) begin
        busy <= 1'b1;
      end else if (out_valid && bus.out_ready && out_last) begin
        busy <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_word  = out_word;
  assign bus.out_idx   = out_idx;
  assign bus.out_last  = out_last;
  assign bus.busy      = busy;

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Sequences the SHA-256 message-schedule datapath: accepts the 16 words of one 512-bit block over a valid/ready input, then expands them into W[0..63] using the small-sigma functions σ0 and σ1. Emits one schedule word per cycle over a registered valid/ready output. Sits between the block buffer and the compression-round engine. Successive blocks run back to back.

## Interface
- `WORD_W`, 32: word width; only 32 is supported.
- `ROUNDS`, 64: schedule length; only 64 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  block will accept `in_word` this cycle.
- `in_word`  in  32  message word, big-endian word order, W0 first.
- `out_valid`  out  1  `out_word` holds a schedule word.
- `out_ready`  in  1  consumer takes `out_word` this cycle.
- `out_word`  out  32  schedule word W[out_idx].
- `out_idx`  out  6  index t of `out_word`, 0..63.
- `out_last`  out  1  high with `out_valid` when `out_idx` = 63.
- `busy`  out  1  high when the block is mid-schedule (any word of the current block accepted and W63 not yet taken).

## Operation
- Window: 16×32 shift register; `win[0]` = W[t-16] … `win[15]` = W[t-1]. A shift drops `win[0]` and writes the new word into `win[15]`.
- Expansion: new = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed mod 2^32 with carries discarded.
  - σ0(x) = rotr7 ^ rotr18 ^ shr3.
  - σ1(x) = rotr17 ^ rotr19 ^ shr10.
- Advance condition: `adv` = !out_valid || out_ready. The output register is reloaded only when `adv` is true.
- States:
  - LOAD, with counter `cnt` 0..15.
    - `in_ready` = adv.
    - On in_valid && in_ready: shift `in_word` into the window; `out_word` ← in_word; `out_idx` ← cnt; `out_valid` ← 1; cnt++.
    - When cnt reaches 15 and that word is accepted: go to EXPAND with t = 16.
  - EXPAND, with t 16..63.
    - `in_ready` = 0.
    - On adv: shift the expansion result in; `out_word` ← result; `out_idx` ← t; `out_valid` ← 1; t++.
    - After t = 63 is loaded: go to LOAD with cnt = 0.
- Output drain: if `adv` is true in LOAD but no input is accepted, `out_valid` ← 0.
  - In EXPAND, `adv` always loads a word, so `out_valid` stays 1.
- Next block: LOAD of the next block may begin while W63 still sits in the output register. W0 of the next block is accepted only once W63 is taken, because `in_ready` = adv.
- Reset (any state, including mid-block):
  - state = LOAD, cnt = 0, `out_valid` = 0, `out_word` = 0, `out_idx` = 0, `out_last` = 0, `busy` = 0.
  - Window cleared to 0.
  - Partial block is discarded. No word is emitted afterwards until new input arrives.
- Misuse: `in_valid` while `in_ready` = 0 is ignored; no word is consumed.

## Timing
- Input to output latency: 1 cycle. A word accepted at edge k is visible on `out_word` with `out_valid` = 1 after edge k.
- Throughput: 1 word/cycle with `in_valid` and `out_ready` held high. One block takes 64 cycles: 16 LOAD + 48 EXPAND.
- Back-to-back blocks: zero-bubble when the consumer never stalls.
- Backpressure: while `out_valid` && !out_ready, `out_word`, `out_idx`, `out_last` and the window hold stable.
- `in_ready` is combinational from state and `out_ready`. There is no combinational path from `in_word` to any output.
- Critical path: 4-operand 32-bit add plus one XOR level. It is not pipelined.

## Structure
- Package `sha256_pkg` holds:
  - `WORD_W`, `N_ROUNDS`, `N_MSG_WORDS` = 16.
  - Rotation/shift constants (7, 18, 3; 17, 19, 10).
  - State enum {LOAD, EXPAND}.
  - 32-bit word typedef.
- Sub-module `sched_sigma`: combinational, parameterised by three amounts (rotr A, rotr B, shr C). It is instantiated twice, as σ0 (7, 18, 3) and σ1 (17, 19, 10).
- The top holds the FSM, counters, window and output register.

## Test plan
- Reset values: assert `rst` 2 cycles.
  - → All outputs = 0 and `in_ready` = 1.
  - Then 16 idle cycles → `out_valid` stays 0.
- "abc" block, `out_ready` = 1:
  - Stimulus: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018.
  - → W16 = 0x61626380, W17 = 0x000F0000, W63 = 0x12B1EDEB.
  - → `out_last` high only at idx 63.
  - → 64 consecutive `out_valid` cycles.
- Backpressure: same block, `out_ready` toggled pseudo-randomly.
  - → Identical 64-word sequence.
  - → `out_word` stable whenever stalled.
  - → `in_ready` = 0 whenever the output is stalled.
- Input gaps: `in_valid` dropped for 3 cycles after W7.
  - → `out_valid` falls during the gap.
  - → Indices remain contiguous.
  - → W16..W63 unchanged.
- Reset mid-EXPAND: assert `rst` at t = 30.
  - → `out_valid` = 0 the next cycle.
  - → A fresh "abc" block then reproduces the W63 = 0x12B1EDEB result.
- Back-to-back: two "abc" blocks with `in_valid`/`out_ready` high.
  - → 128 words with no bubble.
  - → Second W0 appears the cycle after the first W63.
